// File: rtl/if_stage_skid_reg.sv
// IF-stage output register with a one-entry skid buffer: two-deep elastic
// pipeline register between fetch and decode, plus a saturating stall counter.
module if_stage_skid_reg #(
    parameter int unsigned                PC_W      = 32,
    parameter int unsigned                INSTR_W   = 32,
    parameter logic        [INSTR_W-1:0]  NOP_INSTR = 'hF000_0000,
    parameter int unsigned                CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [INSTR_W-1:0] instruction_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instruction,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [PC_W-1:0]    main_pc, main_pc_nxt, skid_pc, skid_pc_nxt;
    logic [INSTR_W-1:0] main_instr, main_instr_nxt, skid_instr, skid_instr_nxt;
    logic               in_fire, out_fire;

    assign in_ready    = (state != TWO);
    assign out_valid   = (state != EMPTY);
    assign pc          = main_pc;
    assign instruction = main_instr;
    assign in_fire     = in_valid & in_ready;
    assign out_fire    = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            main_pc    <= '0;
            main_instr <= NOP_INSTR;
            skid_pc    <= '0;
            skid_instr <= NOP_INSTR;
        end else begin
            state      <= state_nxt;
            main_pc    <= main_pc_nxt;
            main_instr <= main_instr_nxt;
            skid_pc    <= skid_pc_nxt;
            skid_instr <= skid_instr_nxt;
        end
    end

    // The main entry is cleared whenever the stage empties, so pc/instruction
    // can come straight from the register with no output mux.
    always_comb begin
        state_nxt      = state;
        main_pc_nxt    = main_pc;
        main_instr_nxt = main_instr;
        skid_pc_nxt    = skid_pc;
        skid_instr_nxt = skid_instr;
        if (flush) begin
            state_nxt      = EMPTY;
            main_pc_nxt    = '0;
            main_instr_nxt = NOP_INSTR;
            skid_pc_nxt    = '0;
            skid_instr_nxt = NOP_INSTR;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt      = ONE;
                        main_pc_nxt    = pc_in;
                        main_instr_nxt = instruction_in;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_pc_nxt    = pc_in;
                        main_instr_nxt = instruction_in;
                    end else if (in_fire) begin
                        state_nxt      = TWO;
                        skid_pc_nxt    = pc_in;
                        skid_instr_nxt = instruction_in;
                    end else if (out_fire) begin
                        state_nxt      = EMPTY;
                        main_pc_nxt    = '0;
                        main_instr_nxt = NOP_INSTR;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_nxt      = ONE;
                        main_pc_nxt    = skid_pc;
                        main_instr_nxt = skid_instr;
                        skid_pc_nxt    = '0;
                        skid_instr_nxt = NOP_INSTR;
                    end
                end
                default: begin
                    state_nxt      = EMPTY;
                    main_pc_nxt    = '0;
                    main_instr_nxt = NOP_INSTR;
                    skid_pc_nxt    = '0;
                    skid_instr_nxt = NOP_INSTR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage_skid_reg.sv
// Directed and reference-queue checks for if_stage_skid_reg, including a
// CNT_W=2 instance sharing the same stimulus for stall-counter saturation.
module tb_if_stage_skid_reg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'hF000_0000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready, in_ready2;
    logic [PC_W-1:0]    pc_in = '0;
    logic [INSTR_W-1:0] instruction_in = '0;
    logic               flush = 1'b0;
    logic               out_valid, out_valid2;
    logic               out_ready = 1'b0;
    logic [PC_W-1:0]    pc, pc2;
    logic [INSTR_W-1:0] instruction, instruction2;
    logic [15:0]        stall_cnt;
    logic [1:0]         stall_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_stage_skid_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .instruction_in(instruction_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .pc(pc),
        .instruction(instruction), .stall_cnt(stall_cnt)
    );

    if_stage_skid_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .pc_in(pc_in), .instruction_in(instruction_in), .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready), .pc(pc2),
        .instruction(instruction2), .stall_cnt(stall_cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PC_W-1:0] p);
        in_valid       = v;
        pc_in          = p;
        instruction_in = 32'hA500_0000 | p;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
        end
        n_checks++;
        if (pc !== 32'h0 || instruction !== NOP) begin
            n_fail++;
            $display("FAIL reset_data: pc=%h instr=%h, need 0 %h", pc, instruction, NOP);
        end
        n_checks++;
        if (stall_cnt !== 16'd0 || stall_cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_stall: got %0d/%0d, need 0/0", stall_cnt, stall_cnt2);
        end
    endtask

    task automatic test_streaming();
        logic [PC_W-1:0] p;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p = 32'(i * 4);
            drive(1'b1, p);
            step();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || pc !== p || instruction !== (32'hA500_0000 | p)) begin
                n_fail++;
                $display("FAIL stream_%0d: v=%b rdy=%b pc=%h instr=%h, need 1 1 %h %h",
                         i, out_valid, in_ready, pc, instruction, p, 32'hA500_0000 | p);
            end
        end
        drive(1'b0, 32'h0);
        step();
        n_checks++;
        if (out_valid !== 1'b0 || pc !== 32'h0 || instruction !== NOP) begin
            n_fail++;
            $display("FAIL stream_drain: v=%b pc=%h instr=%h, need 0 0 %h", out_valid, pc, instruction, NOP);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h10);
        step();
        drive(1'b1, 32'h14);
        step();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || pc !== 32'h10) begin
            n_fail++;
            $display("FAIL bp_two: rdy=%b v=%b pc=%h, need 0 1 10", in_ready, out_valid, pc);
        end
        drive(1'b1, 32'h18);
        step();
        drive(1'b1, 32'h99);
        step();
        n_checks++;
        if (in_ready !== 1'b0 || pc !== 32'h10 || instruction !== 32'hA500_0010) begin
            n_fail++;
            $display("FAIL bp_hold: rdy=%b pc=%h instr=%h, need 0 10 a5000010", in_ready, pc, instruction);
        end
        out_ready = 1'b1;
        drive(1'b0, 32'h0);
        step();
        n_checks++;
        if (pc !== 32'h14 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: pc=%h v=%b rdy=%b, need 14 1 1", pc, out_valid, in_ready);
        end
        drive(1'b1, 32'h18);
        step();
        n_checks++;
        if (pc !== 32'h18 || instruction !== 32'hA500_0018 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_third: pc=%h instr=%h v=%b, need 18 a5000018 1", pc, instruction, out_valid);
        end
        drive(1'b0, 32'h0);
        step();
        n_checks++;
        if (out_valid !== 1'b0 || pc !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_empty: v=%b pc=%h, need 0 0", out_valid, pc);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h20);
        step();
        drive(1'b1, 32'h24);
        step();
        drive(1'b1, 32'h28);
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || pc !== 32'h0 || instruction !== NOP || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_clear: v=%b pc=%h instr=%h rdy=%b, need 0 0 %h 1",
                     out_valid, pc, instruction, in_ready, NOP);
        end
        drive(1'b0, 32'h0);
        out_ready = 1'b1;
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b0 || pc !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_no_replay: v=%b pc=%h, need 0 0", out_valid, pc);
        end
        // output fire during flush is consumed, not replayed
        drive(1'b1, 32'h30);
        step();
        drive(1'b0, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || pc !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_consumed: v=%b pc=%h, need 0 0", out_valid, pc);
        end
    endtask

    task automatic test_stall_cnt();
        apply_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h40);
        step();
        drive(1'b0, 32'h0);
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL stall_start: got %0d, need 0", stall_cnt);
        end
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (stall_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL stall_five: got %0d, need 5", stall_cnt);
        end
        step();
        n_checks++;
        if (stall_cnt2 !== 2'd3 || stall_cnt !== 16'd6) begin
            n_fail++;
            $display("FAIL stall_saturate: got %0d/%0d, need 6/3", stall_cnt, stall_cnt2);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        n_checks++;
        if (stall_cnt !== 16'd7) begin
            n_fail++;
            $display("FAIL stall_flush: got %0d, need 7", stall_cnt);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h50);
        step();
        drive(1'b1, 32'h54);
        step();
        drive(1'b0, 32'h0);
        step();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || pc !== 32'h0 || instruction !== NOP || stall_cnt !== 16'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: v=%b pc=%h instr=%h stall=%0d rdy=%b, need 0 0 %h 0 1",
                     out_valid, pc, instruction, stall_cnt, in_ready, NOP);
        end
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h60);
        step();
        drive(1'b0, 32'h0);
        n_checks++;
        if (pc !== 32'h60 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL async_restart: pc=%h v=%b, need 60 1", pc, out_valid);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_no_skid: v=%b, need 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [PC_W+INSTR_W-1:0] q[$];
        logic [PC_W+INSTR_W-1:0] head;
        logic [15:0]             exp_stall;
        logic                    m_in_ready, m_out_valid;
        int                      errs;
        apply_reset();
        q.delete();
        exp_stall = '0;
        errs = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid       = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            flush          = ($urandom_range(0, 49) == 0);
            pc_in          = $urandom;
            instruction_in = $urandom;
            m_in_ready  = (q.size() < 2);
            m_out_valid = (q.size() > 0);
            if (m_out_valid && !out_ready && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
            if (flush) begin
                q.delete();
            end else begin
                if (m_out_valid && out_ready) void'(q.pop_front());
                if (in_valid && m_in_ready) q.push_back({pc_in, instruction_in});
            end
            step();
            head = (q.size() > 0) ? q[0] : {32'h0, NOP};
            n_checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || {pc, instruction} !== head
                || stall_cnt !== exp_stall) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cyc%0d: v=%b rdy=%b pc=%h instr=%h stall=%0d, need %b %b %h %h %0d",
                             cyc, out_valid, in_ready, pc, instruction, stall_cnt,
                             q.size() > 0, q.size() < 2, head[PC_W+INSTR_W-1:INSTR_W],
                             head[INSTR_W-1:0], exp_stall);
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_stall_cnt();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage_skid_reg.md
IF_STAGE_SKID_REG -- requirements
Module: if_stage_skid_reg

Interface
REQ-001 Parameter PC_W, default 32: width of the program-counter field.
REQ-002 Parameter INSTR_W, default 32: width of the instruction field.
REQ-003 Parameter NOP_INSTR, default 32'hF000_0000, sized INSTR_W: bubble instruction driven while no valid entry is present.
REQ-004 Parameter CNT_W, default 16: width of the stall counter.
REQ-005 clk  input  1  clock; all state updates occur on the rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 in_valid  input  1  upstream fetch presents pc_in/instruction_in.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 pc_in  input  PC_W  fetched PC.
REQ-010 instruction_in  input  INSTR_W  fetched instruction.
REQ-011 flush  input  1  synchronous kill of all held and incoming entries.
REQ-012 out_valid  output  1  pc/instruction hold a valid entry.
REQ-013 out_ready  input  1  downstream decode accepts the entry this cycle.
REQ-014 pc  output  PC_W  head-entry PC.
REQ-015 instruction  output  INSTR_W  head-entry instruction.
REQ-016 stall_cnt  output  CNT_W  saturating count of back-pressure cycles.

Function
REQ-017 The block SHALL be a 2-entry elastic register: main entry (drives outputs) plus skid entry; occupancy state EMPTY, ONE, TWO.
REQ-018 Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
REQ-019 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, and SHALL depend only on state (no combinational path from out_ready).
REQ-020 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-021 In EMPTY, pc SHALL be 0 and instruction SHALL be NOP_INSTR.
REQ-022 EMPTY: input fire -> ONE, main <= input; else stay.
REQ-023 ONE: input & output fire -> ONE, main <= input; input fire only -> TWO, skid <= input; output fire only -> EMPTY; neither -> hold.
REQ-024 TWO: output fire -> ONE, main <= skid; else hold all contents.
REQ-025 Latency: an entry accepted at edge N SHALL appear on pc/instruction after edge N (one cycle); order SHALL be strictly FIFO; no entry duplicated or dropped absent flush.
REQ-026 Flush SHALL have priority over all transfers: at the edge, state -> EMPTY, both entries discarded, an input fired in the same cycle discarded, outputs become 0/NOP_INSTR.
REQ-027 An output fire in a flush cycle SHALL still count as consumed downstream; the block SHALL not replay it.
REQ-028 stall_cnt SHALL increment by 1 at each edge where out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and be unaffected by flush.
REQ-029 Held contents SHALL not change while input and output both idle, regardless of input data values.

Reset
REQ-030 On rst=1, immediately and asynchronously: state EMPTY, in_ready=1, out_valid=0, pc=0, instruction=NOP_INSTR, stall_cnt=0, skid contents cleared to 0/NOP_INSTR.
REQ-031 Reset asserted mid-operation SHALL discard all entries; the first edge after deassertion SHALL behave as from EMPTY.

Verification
REQ-032 Streaming: out_ready=1, in_valid=1 with pc_in 0,4,8,12 on consecutive edges -> pc 0,4,8,12 one cycle later each, out_valid steady 1, in_ready steady 1.
REQ-033 Back-pressure: out_ready=0, send pc 0x10 then 0x14 -> after 2 edges state TWO, in_ready=0, pc=0x10; third offered 0x18 not accepted; raise out_ready -> outputs 0x10, 0x14, then 0x18 after it is re-offered, no loss.
REQ-034 Flush: state TWO holding 0x20/0x24, flush=1 with in_valid=1 pc_in=0x28 -> next cycle out_valid=0, pc=0, instruction=32'hF000_0000, in_ready=1; 0x28 never appears.
REQ-035 Stall counter: out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; with CNT_W=2, 6 stall cycles -> stall_cnt=3.
REQ-036 Async reset: assert rst between edges in state TWO -> outputs 0/NOP_INSTR, out_valid=0, stall_cnt=0 before next edge.
REQ-037 Random valid/ready/flush traffic for 10,000 cycles against a reference queue model -> output sequence equals accepted-input sequence minus flushed entries.
